// File: rtl/spmv_pkg.sv
// Shared types for the SpMV row accumulator: result record and channel state.
package spmv_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [WORD_W-1:0] row_id;
    logic [WORD_W-1:0] sum;
  } row_result_t;

  typedef enum logic {
    CH_IDLE,
    CH_ACTIVE
  } ch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The pointer holds the top-priority requester, which is
// always one past the most recent grant. N must be a power of two, N >= 2.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] grant_idx;
  logic          found;

  // Search requesters starting at the pointer and wrapping around
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr;
    idx       = ptr;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end

  // Move priority past the winner whenever its grant is consumed
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/spmv_row_accumulator.sv
// Per-channel multiply-accumulate of CISR triples against a dense vector,
// closing rows into one-deep pending slots drained by a round-robin output.
module spmv_row_accumulator
  import spmv_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int VEC_DEPTH    = 256,
  localparam int VEC_AW       = $clog2(VEC_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_l,
  input  logic                                 vec_wr_en,
  input  logic [VEC_AW-1:0]                    vec_wr_addr,
  input  logic [WORD_W-1:0]                    vec_wr_data,
  input  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  in_values,
  input  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  in_col_id,
  input  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  in_row_id,
  input  logic                                 in_rdy,
  input  logic                                 flush,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [WORD_W-1:0]                    res_row_id,
  output logic [WORD_W-1:0]                    res_sum,
  output logic                                 busy,
  output logic                                 pend_overflow,
  output logic                                 col_oob
);

  logic [WORD_W-1:0] vec_ram [VEC_DEPTH];

  logic                                s1_valid;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] s1_value;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] s1_row;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] s1_x;
  logic [NUM_CHANNELS-1:0]             ch_oob;

  ch_state_t                           ch_state      [NUM_CHANNELS];
  ch_state_t                           ch_state_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]             active;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] cur_row;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] acc;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] product;
  logic [NUM_CHANNELS-1:0]             emit;

  logic [NUM_CHANNELS-1:0]             pend_valid;
  row_result_t                         pend_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]             slot_free;
  logic [NUM_CHANNELS-1:0]             drain;
  logic [NUM_CHANNELS-1:0]             grant;
  row_result_t                         granted;
  logic                                load_out;

  logic                                flush_pending;
  logic                                flush_go;
  logic                                flush_done;

  // Any column index with bits above the RAM address range is out of bounds
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_oob[c] = |in_col_id[c][WORD_W-1:VEC_AW];
    end
  end

  // Vector RAM write port and registered per-channel reads (old data on collision)
  always_ff @(posedge clk) begin
    if (vec_wr_en) begin
      vec_ram[vec_wr_addr] <= vec_wr_data;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (in_rdy) begin
        s1_x[c] <= ch_oob[c] ? '0 : vec_ram[in_col_id[c][VEC_AW-1:0]];
      end
    end
  end

  // Capture stage: register the beat and raise the sticky out-of-bounds flag
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_row   <= '0;
      col_oob  <= 1'b0;
    end else begin
      s1_valid <= in_rdy;
      if (in_rdy) begin
        s1_value <= in_values;
        s1_row   <= in_row_id;
        if (|ch_oob) begin
          col_oob <= 1'b1;
        end
      end
    end
  end

  // Signed product truncated to the low word
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      product[c] = WORD_W'($signed(s1_value[c]) * $signed(s1_x[c]));
      active[c]  = (ch_state[c] == CH_ACTIVE);
    end
  end

  assign load_out   = (|pend_valid) && (!res_valid || res_ready);
  assign drain      = grant & {NUM_CHANNELS{load_out}};
  assign slot_free  = ~pend_valid | drain;
  assign flush_go   = flush_pending && !s1_valid && !in_rdy;
  assign flush_done = flush_go && ((active & ~slot_free) == '0);

  // Channel state register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ch_state[c] <= CH_IDLE;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ch_state[c] <= ch_state_next[c];
      end
    end
  end

  // Channel next state: a beat opens a row, a successful flush emit closes it
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_state_next[c] = ch_state[c];
      if (s1_valid) begin
        ch_state_next[c] = CH_ACTIVE;
      end else if (flush_go && active[c] && slot_free[c]) begin
        ch_state_next[c] = CH_IDLE;
      end
    end
  end

  // Channel outputs: emit on a row change, or on flush when the slot can take it
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      emit[c] = 1'b0;
      if (active[c]) begin
        if (s1_valid) begin
          emit[c] = (s1_row[c] != cur_row[c]);
        end else if (flush_go) begin
          emit[c] = slot_free[c];
        end
      end
    end
  end

  // Accumulator datapath: restart on a new row, otherwise add the product
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cur_row <= '0;
      acc     <= '0;
    end else if (s1_valid) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!active[c] || (s1_row[c] != cur_row[c])) begin
          cur_row[c] <= s1_row[c];
          acc[c]     <= product[c];
        end else begin
          acc[c] <= acc[c] + product[c];
        end
      end
    end
  end

  // Flush request stays latched until every active channel has emitted
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      flush_pending <= 1'b0;
    end else begin
      flush_pending <= flush | (flush_pending & ~flush_done);
    end
  end

  // Pending slots: fill on emit, drop with a sticky flag when full and not draining
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_valid    <= '0;
      pend_overflow <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        pend_data[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (emit[c]) begin
          if (slot_free[c]) begin
            pend_valid[c]       <= 1'b1;
            pend_data[c].row_id <= cur_row[c];
            pend_data[c].sum    <= acc[c];
          end else begin
            pend_overflow <= 1'b1;
          end
        end else if (drain[c]) begin
          pend_valid[c] <= 1'b0;
        end
      end
    end
  end

  rr_arbiter #(
    .N(NUM_CHANNELS)
  ) u_arbiter (
    .clk    (clk),
    .rst_l  (rst_l),
    .req    (pend_valid),
    .advance(load_out),
    .grant  (grant)
  );

  // Select the granted slot's contents
  always_comb begin
    granted = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) begin
        granted = pend_data[c];
      end
    end
  end

  // Output register: load when empty or being accepted, hold while stalled
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      res_valid  <= 1'b0;
      res_row_id <= '0;
      res_sum    <= '0;
    end else if (load_out) begin
      res_valid  <= 1'b1;
      res_row_id <= granted.row_id;
      res_sum    <= granted.sum;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign busy = s1_valid | (|active) | (|pend_valid) | res_valid | flush_pending;

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Directed bench with a result scoreboard drained by an independent monitor.
module tb_spmv_row_accumulator;
  import spmv_pkg::*;

  localparam int NCH = 4;

  logic                     clk = 1'b0;
  logic                     rst_l = 1'b0;
  logic                     vec_wr_en = 1'b0;
  logic [7:0]               vec_wr_addr = '0;
  logic [31:0]              vec_wr_data = '0;
  logic [NCH-1:0][31:0]     in_values = '0;
  logic [NCH-1:0][31:0]     in_col_id = '0;
  logic [NCH-1:0][31:0]     in_row_id = '0;
  logic                     in_rdy = 1'b0;
  logic                     flush = 1'b0;
  logic                     res_valid;
  logic                     res_ready = 1'b1;
  logic [31:0]              res_row_id;
  logic [31:0]              res_sum;
  logic                     busy;
  logic                     pend_overflow;
  logic                     col_oob;

  row_result_t exp_q[$];
  row_result_t exp_item;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spmv_row_accumulator #(
    .NUM_CHANNELS(NCH),
    .VEC_DEPTH   (256)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .vec_wr_en    (vec_wr_en),
    .vec_wr_addr  (vec_wr_addr),
    .vec_wr_data  (vec_wr_data),
    .in_values    (in_values),
    .in_col_id    (in_col_id),
    .in_row_id    (in_row_id),
    .in_rdy       (in_rdy),
    .flush        (flush),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_row_id   (res_row_id),
    .res_sum      (res_sum),
    .busy         (busy),
    .pend_overflow(pend_overflow),
    .col_oob      (col_oob)
  );

  // Monitor: every accepted result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (rst_l && res_valid && res_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard: unexpected result row %0d sum 0x%08h, required no output",
                 res_row_id, res_sum);
      end else begin
        exp_item = exp_q.pop_front();
        if (res_row_id !== exp_item.row_id || res_sum !== exp_item.sum) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: got row %0d sum 0x%08h, required row %0d sum 0x%08h",
                   res_row_id, res_sum, exp_item.row_id, exp_item.sum);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectResult(input logic [31:0] row, input logic [31:0] sum);
    row_result_t r;
    r.row_id = row;
    r.sum    = sum;
    exp_q.push_back(r);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0][31:0] v, input logic [NCH-1:0][31:0] c,
                               input logic [NCH-1:0][31:0] r, input logic fl);
    in_values = v;
    in_col_id = c;
    in_row_id = r;
    in_rdy    = 1'b1;
    flush     = fl;
    tick(1);
    in_rdy = 1'b0;
    flush  = 1'b0;
  endtask

  // Channel 0 gets the given triple; channels 1..3 hold value 0 on row fill_base+k
  task automatic beat(input logic [31:0] v, input logic [31:0] c, input logic [31:0] r,
                      input logic [31:0] fill_base, input logic fl);
    logic [NCH-1:0][31:0] vv, vc, vr;
    vv[0] = v;
    vc[0] = c;
    vr[0] = r;
    for (int k = 1; k < NCH; k++) begin
      vv[k] = '0;
      vc[k] = '0;
      vr[k] = fill_base + 32'(k);
    end
    applyStimulus(vv, vc, vr, fl);
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic writeVec(input logic [7:0] a, input logic [31:0] d);
    vec_wr_en   = 1'b1;
    vec_wr_addr = a;
    vec_wr_data = d;
    tick(1);
    vec_wr_en = 1'b0;
  endtask

  task automatic doReset();
    rst_l = 1'b0;
    tick(1);
    rst_l = 1'b1;
    tick(1);
  endtask

  task automatic waitDrain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s drain: %0d results still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  initial begin
    logic [NCH-1:0][31:0] vv, vc, vr;

    tick(1);
    writeVec(8'd0, 32'd1);
    writeVec(8'd1, 32'd2);
    writeVec(8'd2, 32'd3);
    writeVec(8'd3, 32'd4);

    // Test 1: basic accumulate, row change, flush and first-result latency
    $display("[TB] test 1: accumulate and flush");
    doReset();
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset pend_overflow", 32'(pend_overflow), 32'd0);
    checkOutput("reset col_oob", 32'(col_oob), 32'd0);
    expectResult(32'd0, 32'd29);
    expectResult(32'd101, 32'd0);
    expectResult(32'd102, 32'd0);
    expectResult(32'd103, 32'd0);
    expectResult(32'd1, 32'd14);
    beat(32'd5, 32'd0, 32'd0, 32'd100, 1'b0);
    beat(32'd6, 32'd3, 32'd0, 32'd100, 1'b0);
    beat(32'd7, 32'd1, 32'd1, 32'd100, 1'b0);
    pulseFlush();
    checkOutput("t1 res_valid at N+2", 32'(res_valid), 32'd0);
    tick(1);
    checkOutput("t1 res_valid at N+3", 32'(res_valid), 32'd1);
    checkOutput("t1 res_row_id at N+3", res_row_id, 32'd0);
    checkOutput("t1 res_sum at N+3", res_sum, 32'd29);
    waitDrain("t1");
    checkOutput("t1 busy idle", 32'(busy), 32'd0);

    // Test 2: all channels close together, round-robin order from channel 0
    $display("[TB] test 2: simultaneous row close");
    doReset();
    for (int k = 0; k < NCH; k++) begin
      vv[k] = 32'(k);
      vc[k] = '0;
      vr[k] = 32'(10 + k);
    end
    applyStimulus(vv, vc, vr, 1'b0);
    for (int k = 0; k < NCH; k++) begin
      vv[k] = 32'd1;
      vr[k] = 32'(20 + k);
      expectResult(32'(10 + k), 32'(k));
    end
    applyStimulus(vv, vc, vr, 1'b0);
    tick(2);
    for (int i = 0; i < NCH; i++) begin
      checkOutput("t2 back-to-back valid", 32'(res_valid), 32'd1);
      checkOutput("t2 back-to-back row", res_row_id, 32'(10 + i));
      tick(1);
    end
    waitDrain("t2 close");
    for (int k = 0; k < NCH; k++) begin
      expectResult(32'(20 + k), 32'd1);
    end
    pulseFlush();
    waitDrain("t2 flush");

    // Test 3: stalled output, one result held, one pending, one dropped
    $display("[TB] test 3: backpressure and overflow");
    doReset();
    res_ready = 1'b0;
    expectResult(32'd0, 32'd1);
    expectResult(32'd1, 32'd1);
    for (int r = 0; r < 4; r++) begin
      beat(32'd1, 32'd0, 32'(r), 32'd200, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      checkOutput("t3 held res_row_id", res_row_id, 32'd0);
      tick(1);
    end
    checkOutput("t3 held res_valid", 32'(res_valid), 32'd1);
    checkOutput("t3 held res_sum", res_sum, 32'd1);
    checkOutput("t3 pend_overflow", 32'(pend_overflow), 32'd1);
    res_ready = 1'b1;
    waitDrain("t3 release");
    checkOutput("t3 no dropped row", 32'(res_valid), 32'd0);
    expectResult(32'd201, 32'd0);
    expectResult(32'd202, 32'd0);
    expectResult(32'd203, 32'd0);
    expectResult(32'd3, 32'd1);
    pulseFlush();
    waitDrain("t3 flush");

    // Test 4: out-of-range column reads as zero and sets the sticky flag
    $display("[TB] test 4: column out of bounds");
    doReset();
    checkOutput("t4 col_oob before", 32'(col_oob), 32'd0);
    expectResult(32'd5, 32'd0);
    expectResult(32'd51, 32'd0);
    expectResult(32'd52, 32'd0);
    expectResult(32'd53, 32'd0);
    beat(32'd9, 32'd300, 32'd5, 32'd50, 1'b0);
    pulseFlush();
    checkOutput("t4 col_oob after", 32'(col_oob), 32'd1);
    waitDrain("t4");

    // Test 5: asynchronous reset in the middle of an open row
    $display("[TB] test 5: reset mid-row");
    beat(32'd50, 32'd1, 32'd9, 32'd60, 1'b0);
    tick(2);
    checkOutput("t5 busy before reset", 32'(busy), 32'd1);
    rst_l = 1'b0;
    #1;
    checkOutput("t5 reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("t5 reset res_row_id", res_row_id, 32'd0);
    checkOutput("t5 reset res_sum", res_sum, 32'd0);
    checkOutput("t5 reset busy", 32'(busy), 32'd0);
    checkOutput("t5 reset col_oob", 32'(col_oob), 32'd0);
    checkOutput("t5 reset pend_overflow", 32'(pend_overflow), 32'd0);
    tick(1);
    rst_l = 1'b1;
    tick(1);
    expectResult(32'd7, 32'd2);
    expectResult(32'd71, 32'd0);
    expectResult(32'd72, 32'd0);
    expectResult(32'd73, 32'd0);
    beat(32'd2, 32'd0, 32'd7, 32'd70, 1'b0);
    pulseFlush();
    waitDrain("t5");

    // Test 6: signed wrap, with flush arriving on the same cycle as a beat
    $display("[TB] test 6: signed wrap");
    doReset();
    expectResult(32'd8, 32'hFFFF_FFFC);
    expectResult(32'd81, 32'd0);
    expectResult(32'd82, 32'd0);
    expectResult(32'd83, 32'd0);
    beat(32'h7FFF_FFFF, 32'd1, 32'd8, 32'd80, 1'b0);
    beat(32'h7FFF_FFFF, 32'd1, 32'd8, 32'd80, 1'b1);
    waitDrain("t6");
    checkOutput("t6 busy idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
